bit_serial_alu: RTL



---
 rtl/alu_pkg.sv | 18 +
 rtl/serial_alu_slice.sv | 24 ++
 rtl/bit_serial_alu.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control encodings ({ainvert, bnegate, op[1:0]}) and the
// serial ALU sequencer states.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_alu_slice.sv
// Combinational 1-bit ALU slice: optional operand inversion, AND/OR/full-add.
module serial_alu_slice (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    input  logic ainvert_i,
    input  logic bnegate_i,
    output logic and_o,
    output logic or_o,
    output logic sum_o,
    output logic cout_o
);

    logic a_g;
    logic b_g;

    assign a_g    = a_i ^ ainvert_i;
    assign b_g    = b_i ^ bnegate_i;
    assign and_o  = a_g & b_g;
    assign or_o   = a_g | b_g;
    assign sum_o  = a_g ^ b_g ^ cin_i;
    assign cout_o = (a_g & b_g) | (cin_i & (a_g ^ b_g));

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: one operand bit per clock, LSB first, through one slice.
// Optional BIT_SERIAL_ALU_OVF_EN adds the overflow_o result port.
module bit_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [3:0]       alu_ctl_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] result_o,
`ifdef BIT_SERIAL_ALU_OVF_EN
    output logic             overflow_o,
`endif
    output logic             zero_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]       ctl_q, ctl_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             s_and, s_or, s_sum, s_cout;
    logic             res_bit, ovf, set, last;
`ifdef BIT_SERIAL_ALU_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    serial_alu_slice u_slice (
        .a_i       (a_q[0]),
        .b_i       (b_q[0]),
        .cin_i     (carry_q),
        .ainvert_i (ctl_q[3]),
        .bnegate_i (ctl_q[2]),
        .and_o     (s_and),
        .or_o      (s_or),
        .sum_o     (s_sum),
        .cout_o    (s_cout)
    );

    assign last = (cnt_q == CNT_W'(WIDTH - 1));
    // Only meaningful on the MSB cycle, where carry_q is the carry into the MSB.
    assign ovf  = carry_q ^ s_cout;
    assign set  = s_sum ^ ovf;

    always_comb begin
        res_bit = 1'b0;
        unique case (ctl_q)
            ALU_AND, ALU_NOR: res_bit = s_and;
            ALU_OR:           res_bit = s_or;
            ALU_ADD, ALU_SUB: res_bit = s_sum;
            default:          res_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        ctl_d   = ctl_q;
        carry_d = carry_q;
        zero_d  = zero_q;
`ifdef BIT_SERIAL_ALU_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    ctl_d   = alu_ctl_i;
                    carry_d = alu_ctl_i[2];
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = {res_bit, res_q[WIDTH-1:1]};
                carry_d = s_cout;
                if (last) begin
                    if (ctl_q == ALU_SLT) res_d = {{(WIDTH-1){1'b0}}, set};
                    zero_d  = (res_d == '0);
`ifdef BIT_SERIAL_ALU_OVF_EN
                    ovf_d   = ovf && (ctl_q == ALU_ADD || ctl_q == ALU_SUB || ctl_q == ALU_SLT);
`endif
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (res_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ctl_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
`ifdef BIT_SERIAL_ALU_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ctl_q   <= ctl_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
`ifdef BIT_SERIAL_ALU_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign res_valid_o = (state_q == DONE);
    assign result_o    = res_q;
    assign zero_o      = zero_q;
`ifdef BIT_SERIAL_ALU_OVF_EN
    assign overflow_o  = ovf_q;
`endif

endmodule
